piso_shift_register: RTL and testbench

Parallel-in serial-out transmitter: the sending end of the serial link whose receiver is `sipo_shift_register`. It accepts a `WIDTH`-bit word through a valid/ready handshake and shifts it out LSB first. Each bit is consumed on a cycle where `enable` is high. A one-word holding buffer lets consecutive words leave with no gap between them. Driving a `sipo_shift_register` from `out`, with the same `enable`, reassembles the words on the receive side.

---
 rtl/piso_shift_register.sv | 72 +++++++
 tb/tb_piso_shift_register.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/piso_shift_register.sv
// Parallel-in serial-out transmitter: accepts WIDTH-bit words over valid/ready and
// shifts them out LSB first, one bit per enable strobe, with a one-word holding buffer.
module piso_shift_register #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             enable,
  output logic             out,
  output logic             out_valid,
  output logic             word_last,
  output logic             word_done
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic { IDLE = 1'b0, SHIFT = 1'b1 } state_t;

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] hold_data;
  logic [CW-1:0]    bit_cnt;
  logic             hold_full;

  logic active, accept, consume, at_last, load;

  assign active   = (state == SHIFT);
  assign in_ready = !hold_full && !rst;
  assign accept   = in_valid && in_ready;
  assign consume  = active && enable;
  assign at_last  = (bit_cnt == LAST);
  // Refill on the edge that consumes the last bit, so the next word follows with no gap.
  assign load     = hold_full && (!active || (consume && at_last));

  assign out       = active ? shreg[0] : 1'b0;
  assign out_valid = active;
  assign word_last = active && at_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      shreg     <= '0;
      hold_data <= '0;
      bit_cnt   <= '0;
      hold_full <= 1'b0;
      word_done <= 1'b0;
    end else begin
      word_done <= consume && at_last;

      // accept and load are mutually exclusive: one needs hold_full low, the other high
      if (accept) begin
        hold_data <= in_data;
        hold_full <= 1'b1;
      end else if (load) begin
        hold_full <= 1'b0;
      end

      if (load) begin
        shreg   <= hold_data;
        bit_cnt <= '0;
        state   <= SHIFT;
      end else if (consume) begin
        shreg <= shreg >> 1;
        if (at_last) state   <= IDLE;
        else         bit_cnt <= bit_cnt + CW'(1);
      end
    end
  end
endmodule

// File: tb/tb_piso_shift_register.sv
// Directed bench for piso_shift_register: table-driven single word plus stream,
// backpressure, stall, reset and 32-bit loopback sequences.
module tb_piso_shift_register;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] in_data;
  logic         in_valid, enable;
  logic         in_ready, out, out_valid, word_last, word_done;

  logic [31:0]  d32;
  logic         v32, en32;
  logic         r32, o32, ov32, wl32, wd32;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  piso_shift_register #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .enable(enable), .out(out), .out_valid(out_valid), .word_last(word_last),
    .word_done(word_done)
  );

  piso_shift_register #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .in_data(d32), .in_valid(v32), .in_ready(r32),
    .enable(en32), .out(o32), .out_valid(ov32), .word_last(wl32),
    .word_done(wd32)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Each row: drive these inputs, take one edge, then expect these outputs.
  typedef struct {
    logic       vld;
    logic [7:0] data;
    logic       en;
    logic       o, ov, wl, wd, rdy;
  } vec_t;

  function automatic vec_t mk(input logic vld, input logic [7:0] data, input logic en,
                              input logic o, input logic ov, input logic wl,
                              input logic wd, input logic rdy);
    vec_t v;
    v.vld = vld; v.data = data; v.en = en;
    v.o = o; v.ov = ov; v.wl = wl; v.wd = wd; v.rdy = rdy;
    return v;
  endfunction

  logic [7:0] words[4];
  logic       bits_q[$];
  int         done_q[$];
  int         max_run, hold_err, acc_before_en;
  logic       rdy_probe;

  // Offer words[0..n-1] with in_valid held, strobe enable every `period` cycles from
  // en_start, and record consumed bits, word_done cycles and stall stability.
  task automatic run_stream(input int n, input int en_start, input int period, input int budget);
    int   idx = 0;
    int   cyc = 0;
    int   run = 0;
    logic p_en = 1'b1, p_o = 1'b0, p_ov = 1'b0, p_wl = 1'b0;
    logic fire;
    bits_q.delete();
    done_q.delete();
    max_run = 0; hold_err = 0; acc_before_en = 0; rdy_probe = 1'b1;
    while (cyc < budget && done_q.size() < n) begin
      in_valid = (idx < n);
      in_data  = (idx < n) ? words[idx] : 8'h00;
      enable   = (cyc >= en_start) && (((cyc - en_start) % period) == 0);
      #1;
      if (!p_en && p_ov && (out !== p_o || out_valid !== p_ov || word_last !== p_wl))
        hold_err++;
      fire = in_valid && in_ready;
      if (cyc == en_start - 1) rdy_probe = in_ready;
      if (fire && cyc < en_start) acc_before_en++;
      if (out_valid && enable) bits_q.push_back(out);
      if (word_done) done_q.push_back(cyc);
      run = out_valid ? run + 1 : 0;
      if (run > max_run) max_run = run;
      p_en = enable; p_o = out; p_ov = out_valid; p_wl = word_last;
      @(posedge clk);
      #1;
      if (fire) idx++;
      cyc++;
    end
    in_valid = 1'b0;
    enable   = 1'b0;
    chk("stream_timeout_done_count", done_q.size(), n);
  endtask

  function automatic logic [7:0] rx_byte(input int k);
    logic [7:0] b;
    b = '0;
    for (int i = 0; i < 8; i++)
      if (8 * k + i < bits_q.size()) b[i] = bits_q[8 * k + i];
    return b;
  endfunction

  vec_t vec[11];

  initial begin
    logic [31:0] rx;
    logic [31:0] rx_q[$];
    int          cnt, wl_err, wd_cnt, ov_err, guard;

    rst = 1'b1; in_valid = 1'b0; in_data = '0; enable = 1'b0;
    v32 = 1'b0; d32 = '0; en32 = 1'b0;

    // Reset values while rst is high, then release.
    #2;
    chk("reset_out", out, 0);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_in_ready", in_ready, 0);
    chk("reset_word_done", word_done, 0);
    chk("reset_word_last", word_last, 0);
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("release_in_ready", in_ready, 1);

    // Single word 0xA5, enable held high: bits 1,0,1,0,0,1,0,1.
    vec[0]  = mk(1, 8'hA5, 1, 0, 0, 0, 0, 0);
    vec[1]  = mk(0, 8'h00, 1, 1, 1, 0, 0, 1);
    vec[2]  = mk(0, 8'h00, 1, 0, 1, 0, 0, 1);
    vec[3]  = mk(0, 8'h00, 1, 1, 1, 0, 0, 1);
    vec[4]  = mk(0, 8'h00, 1, 0, 1, 0, 0, 1);
    vec[5]  = mk(0, 8'h00, 1, 0, 1, 0, 0, 1);
    vec[6]  = mk(0, 8'h00, 1, 1, 1, 0, 0, 1);
    vec[7]  = mk(0, 8'h00, 1, 0, 1, 0, 0, 1);
    vec[8]  = mk(0, 8'h00, 1, 1, 1, 1, 0, 1);
    vec[9]  = mk(0, 8'h00, 1, 0, 0, 0, 1, 1);
    vec[10] = mk(0, 8'h00, 1, 0, 0, 0, 0, 1);
    for (int i = 0; i < 11; i++) begin
      in_valid = vec[i].vld;
      in_data  = vec[i].data;
      enable   = vec[i].en;
      tick();
      chk($sformatf("vec%0d_out", i), out, vec[i].o);
      chk($sformatf("vec%0d_out_valid", i), out_valid, vec[i].ov);
      chk($sformatf("vec%0d_word_last", i), word_last, vec[i].wl);
      chk($sformatf("vec%0d_word_done", i), word_done, vec[i].wd);
      chk($sformatf("vec%0d_in_ready", i), in_ready, vec[i].rdy);
    end
    in_valid = 1'b0; enable = 1'b0;
    tick();

    // Gapless pair 0x3C, 0xC3.
    words[0] = 8'h3C; words[1] = 8'hC3;
    run_stream(2, 0, 1, 60);
    chk("gapless_bits", bits_q.size(), 16);
    chk("gapless_w0", rx_byte(0), 8'h3C);
    chk("gapless_w1", rx_byte(1), 8'hC3);
    chk("gapless_run", max_run, 16);
    if (done_q.size() == 2) chk("gapless_done_spacing", done_q[1] - done_q[0], 8);
    tick();

    // Backpressure: three words queued while enable stays low.
    words[0] = 8'h81; words[1] = 8'h7E; words[2] = 8'h5A;
    run_stream(3, 10, 1, 80);
    chk("bp_accepts_before_enable", acc_before_en, 2);
    chk("bp_in_ready_stalled", rdy_probe, 0);
    chk("bp_bits", bits_q.size(), 24);
    chk("bp_w0", rx_byte(0), 8'h81);
    chk("bp_w1", rx_byte(1), 8'h7E);
    chk("bp_w2", rx_byte(2), 8'h5A);
    chk("bp_hold_stable", hold_err, 0);
    tick();

    // Enable every third cycle during 0x5A.
    words[0] = 8'h5A;
    run_stream(1, 0, 3, 60);
    chk("gap_bits", bits_q.size(), 8);
    chk("gap_w0", rx_byte(0), 8'h5A);
    chk("gap_hold_stable", hold_err, 0);

    // enable strobes while IDLE change nothing.
    for (int i = 0; i < 6; i++) begin
      enable = (i % 2 == 0);
      tick();
      chk($sformatf("idle_strobe%0d", i), {out, out_valid, word_last, word_done, in_ready}, 5'b00001);
    end
    enable = 1'b0;

    // Reset mid-word with a second word held.
    in_valid = 1'b1; in_data = 8'hA5;
    tick();
    in_data = 8'h3C;
    tick();
    tick();
    in_valid = 1'b0; enable = 1'b1;
    tick(); tick(); tick();
    chk("midword_pre_valid", out_valid, 1);
    chk("midword_pre_in_ready", in_ready, 0);
    #2;
    rst = 1'b1;
    #1;
    chk("midword_rst_out", out, 0);
    chk("midword_rst_out_valid", out_valid, 0);
    chk("midword_rst_word_last", word_last, 0);
    chk("midword_rst_in_ready", in_ready, 0);
    chk("midword_rst_word_done", word_done, 0);
    tick();
    rst = 1'b0;
    #1;
    chk("midword_release_in_ready", in_ready, 1);
    ov_err = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (out_valid !== 1'b0 || word_done !== 1'b0) ov_err++;
    end
    chk("midword_no_resume", ov_err, 0);
    enable = 1'b0;

    // 32-bit loopback through a receive model sharing enable.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    words[0] = 8'h00;
    cnt = 0; wl_err = 0; wd_cnt = 0; guard = 0; rx = '0;
    rx_q.delete();
    begin
      logic [31:0] tx[2];
      int          idx;
      logic        fire;
      tx[0] = 32'hDEADBEEF; tx[1] = 32'h00000001;
      idx = 0;
      en32 = 1'b1;
      while (rx_q.size() < 2 && guard < 200) begin
        v32 = (idx < 2);
        d32 = (idx < 2) ? tx[idx] : 32'h0;
        #1;
        fire = v32 && r32;
        if (wd32) wd_cnt++;
        if (ov32 && en32) begin
          if (wl32 !== (cnt == 31)) wl_err++;
          rx = {o32, rx[31:1]};
          cnt++;
          if (cnt == 32) begin
            rx_q.push_back(rx);
            cnt = 0;
          end
        end
        @(posedge clk);
        #1;
        if (fire) idx++;
        guard++;
      end
      v32 = 1'b0; en32 = 1'b0;
    end
    chk("loop_timeout_words", rx_q.size(), 2);
    if (rx_q.size() == 2) begin
      chk("loop_w0", rx_q[0], 32'hDEADBEEF);
      chk("loop_w1", rx_q[1], 32'h00000001);
    end
    chk("loop_word_last", wl_err, 0);
    #1;
    if (wd32) wd_cnt++;
    chk("loop_word_done_count", wd_cnt, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
